useq_ctrl: RTL and testbench

Microprogram sequencer for the CISC control unit. Holds the micro-program counter (uPC) that addresses the control store, steps it one microinstruction per cycle, and performs the two decode dispatches using the instruction decoder's 3-bit targets: `ib` for execute and `sb` for operand/addressing. It also stalls on memory, stops on the halt opcode, and counts retired instructions.

---
 rtl/useq_ctrl.sv | 124 ++++++++++++
 tb/tb_useq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/useq_ctrl.sv
// Microprogram sequencer: holds the uPC that addresses the control store,
// steps it one microword per cycle, performs the operand (sb) and execute (ib)
// decode dispatches, stalls on memory, stops on the halt opcode and counts
// retired instructions.
module useq_ctrl #(
    parameter int UADDR_W = 6,   // control-store layout below assumes 6
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         ib,
    input  logic [2:0]         sb,
    input  logic [1:0]         nac,
    input  logic               uwait,
    input  logic               mem_ready,
    output logic [UADDR_W-1:0] uaddr,
    output logic               running,
    output logic               halted,
    output logic               stall,
    output logic [CNT_W-1:0]   instr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Next-address-control encodings of the current microword.
    localparam logic [1:0] NAC_NEXT      = 2'b00;
    localparam logic [1:0] NAC_DISP_OPER = 2'b01;
    localparam logic [1:0] NAC_DISP_EXEC = 2'b10;
    localparam logic [1:0] NAC_FETCH     = 2'b11;

    state_t               state_q, state_d;
    logic [UADDR_W-1:0]   uaddr_q, uaddr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    // Routine entry points: operand routines live in the lower half of the
    // store, execute routines in the upper half, four words per routine.
    logic [UADDR_W-1:0]   oper_target;
    logic [UADDR_W-1:0]   exec_target;

    assign oper_target = UADDR_W'({1'b0, sb, 2'b00});
    assign exec_target = UADDR_W'({1'b1, ib, 2'b00});

    assign running   = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALTED);
    // A waiting microword releases in the same cycle memory is ready, so the
    // handshake costs no extra cycle.
    assign stall     = running & uwait & ~mem_ready;
    assign uaddr     = uaddr_q;
    assign instr_cnt = cnt_q;

    // State, uPC and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q <= ST_IDLE;
            uaddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-uPC and counter logic; stall takes priority over nac.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        uaddr_d = uaddr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                uaddr_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!stall) begin
                    unique case (nac)
                        NAC_NEXT: begin
                            uaddr_d = uaddr_q + UADDR_W'(1);
                        end
                        NAC_DISP_OPER, NAC_DISP_EXEC: begin
                            // An instruction without an operand phase falls
                            // straight through to its execute dispatch.
                            if (nac == NAC_DISP_OPER && sb != 3'd0) begin
                                uaddr_d = oper_target;
                            end else if (ib != 3'd0) begin
                                uaddr_d = exec_target;
                            end else begin
                                // Halt opcode: stop without retiring.
                                state_d = ST_HALTED;
                                uaddr_d = '0;
                            end
                        end
                        NAC_FETCH: begin
                            uaddr_d = '0;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                        default: begin
                            uaddr_d = uaddr_q;
                        end
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
                uaddr_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_useq_ctrl.sv
// Directed bench for useq_ctrl: a vector table for the main stepping and
// dispatch behaviour, then hand-written sequences for uPC wrap, counter wrap
// and reset during a stall.
module tb_useq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  ib;
    logic [2:0]  sb;
    logic [1:0]  nac;
    logic        uwait;
    logic        mem_ready;
    logic [5:0]  uaddr;
    logic        running;
    logic        halted;
    logic        stall;
    logic [15:0] instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    useq_ctrl #(.UADDR_W(6), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ib        (ib),
        .sb        (sb),
        .nac       (nac),
        .uwait     (uwait),
        .mem_ready (mem_ready),
        .uaddr     (uaddr),
        .running   (running),
        .halted    (halted),
        .stall     (stall),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs held for one cycle, the stall expected during that
    // cycle, and the outputs expected just after the following edge.
    typedef struct {
        logic        start;
        logic [1:0]  nac;
        logic [2:0]  sb;
        logic [2:0]  ib;
        logic        uwait;
        logic        mem_ready;
        logic        exp_stall;
        logic [5:0]  exp_uaddr;
        logic        exp_run;
        logic        exp_halt;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [1:0] n,
                                input logic [2:0] s, input logic [2:0] i,
                                input logic uw, input logic mr,
                                input logic e_st, input logic [5:0] e_ua,
                                input logic e_run, input logic e_halt,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.start = st; v.nac = n; v.sb = s; v.ib = i;
        v.uwait = uw; v.mem_ready = mr;
        v.exp_stall = e_st; v.exp_uaddr = e_ua;
        v.exp_run = e_run; v.exp_halt = e_halt; v.exp_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic [1:0] n,
                          input logic [2:0] s, input logic [2:0] i,
                          input logic uw, input logic mr);
        start = st; nac = n; sb = s; ib = i; uwait = uw; mem_ready = mr;
    endtask

    task automatic check_outs(input string tag, input logic [5:0] e_ua,
                              input logic e_run, input logic e_halt,
                              input logic [15:0] e_cnt);
        check({tag, ".uaddr"},     32'(uaddr),     32'(e_ua));
        check({tag, ".running"},   32'(running),   32'(e_run));
        check({tag, ".halted"},    32'(halted),    32'(e_halt));
        check({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(e_cnt));
    endtask

    logic [15:0] exp_cnt;

    initial begin
        reset = 1'b1;
        set_in(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
        step();
        step();
        check_outs("reset", 6'd0, 1'b0, 1'b0, 16'd0);
        check("reset.stall", 32'(stall), 32'd0);
        reset = 1'b0;

        //               st nac    sb    ib    uw  mr  stl ua     run hlt cnt
        vecs.push_back(mk(1, 2'b00, 3'd0, 3'd0, 1, 0,  0, 6'd0,  1, 0, 16'd0)); // start; uwait ignored in IDLE
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 0, 0,  0, 6'd1,  1, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 0, 0,  0, 6'd2,  1, 0, 16'd0));
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 0, 0,  0, 6'd3,  1, 0, 16'd0));
        vecs.push_back(mk(0, 2'b01, 3'd2, 3'd6, 0, 0,  0, 6'd8,  1, 0, 16'd0)); // operand dispatch
        vecs.push_back(mk(0, 2'b10, 3'd2, 3'd6, 0, 0,  0, 6'd56, 1, 0, 16'd0)); // execute dispatch
        vecs.push_back(mk(0, 2'b11, 3'd0, 3'd0, 0, 0,  0, 6'd0,  1, 0, 16'd1)); // retire
        vecs.push_back(mk(0, 2'b01, 3'd0, 3'd7, 0, 0,  0, 6'd60, 1, 0, 16'd1)); // sb=0 skips operand phase
        vecs.push_back(mk(0, 2'b11, 3'd0, 3'd0, 0, 0,  0, 6'd0,  1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b01, 3'd0, 3'd0, 0, 0,  0, 6'd0,  0, 1, 16'd2)); // halt opcode
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 1, 0,  0, 6'd0,  0, 1, 16'd2)); // stays halted
        vecs.push_back(mk(1, 2'b00, 3'd0, 3'd0, 0, 0,  0, 6'd0,  1, 0, 16'd2)); // restart
        vecs.push_back(mk(1, 2'b00, 3'd0, 3'd0, 0, 0,  0, 6'd1,  1, 0, 16'd2)); // start ignored in RUN
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 0, 0,  0, 6'd2,  1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 1, 0,  1, 6'd2,  1, 0, 16'd2)); // stall x4
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 1, 0,  1, 6'd2,  1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 1, 0,  1, 6'd2,  1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 1, 0,  1, 6'd2,  1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b00, 3'd0, 3'd0, 1, 1,  0, 6'd3,  1, 0, 16'd2)); // zero-bubble release
        vecs.push_back(mk(0, 2'b10, 3'd5, 3'd3, 0, 0,  0, 6'd44, 1, 0, 16'd2)); // DISP_EXEC ignores sb
        vecs.push_back(mk(0, 2'b01, 3'd7, 3'd0, 0, 0,  0, 6'd28, 1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b01, 3'd1, 3'd0, 0, 0,  0, 6'd4,  1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b10, 3'd0, 3'd1, 0, 0,  0, 6'd36, 1, 0, 16'd2));
        vecs.push_back(mk(0, 2'b11, 3'd0, 3'd0, 1, 0,  1, 6'd36, 1, 0, 16'd2)); // no count while stalled
        vecs.push_back(mk(0, 2'b11, 3'd0, 3'd0, 0, 0,  0, 6'd0,  1, 0, 16'd3));
        vecs.push_back(mk(0, 2'b10, 3'd0, 3'd0, 1, 0,  1, 6'd0,  1, 0, 16'd3)); // halt masked by stall

        foreach (vecs[k]) begin
            set_in(vecs[k].start, vecs[k].nac, vecs[k].sb, vecs[k].ib,
                   vecs[k].uwait, vecs[k].mem_ready);
            #1;
            check($sformatf("v%0d.stall", k), 32'(stall), 32'(vecs[k].exp_stall));
            step();
            check_outs($sformatf("v%0d", k), vecs[k].exp_uaddr,
                       vecs[k].exp_run, vecs[k].exp_halt, vecs[k].exp_cnt);
        end

        // uPC wrap: 63 NEXTs from 0 reach 63, one more returns to 0.
        set_in(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) step();
        check("wrap.uaddr63", 32'(uaddr), 32'd63);
        step();
        check("wrap.uaddr0", 32'(uaddr), 32'd0);

        // Counter wrap: retire until 0xFFFF, then one more.
        exp_cnt = 16'd3;
        nac = 2'b11;
        while (exp_cnt != 16'hFFFF) begin
            step();
            exp_cnt = exp_cnt + 16'd1;
        end
        check("cnt.ffff", 32'(instr_cnt), 32'hFFFF);
        step();
        check("cnt.wrap", 32'(instr_cnt), 32'h0000);
        check("cnt.uaddr", 32'(uaddr), 32'd0);

        // Reset during a stall at uaddr 40, with start held high.
        set_in(1'b0, 2'b10, 3'd0, 3'd2, 1'b0, 1'b0);
        step();
        check("rst.uaddr40", 32'(uaddr), 32'd40);
        set_in(1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0);
        step();
        check("rst.stall_pre", 32'(stall), 32'd1);
        check("rst.hold40", 32'(uaddr), 32'd40);
        reset = 1'b1;
        start = 1'b1;
        step();
        check_outs("rst1", 6'd0, 1'b0, 1'b0, 16'd0);
        check("rst1.stall", 32'(stall), 32'd0);
        step();
        check_outs("rst2", 6'd0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        start = 1'b0;
        step();
        check_outs("idle", 6'd0, 1'b0, 1'b0, 16'd0);
        start = 1'b1;
        step();
        check_outs("restart", 6'd0, 1'b1, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
